cart_mem_arbiter: RTL and testbench
===================================

// Module: cart_mem_arbiter
// PURPOSE
//  Shares the single cartridge SDRAM port between three requesters: Z80 cartridge-slot reads,
//  ioctl ROM-download writes and periodic SDRAM auto-refresh. Sits between cart_rom's slot
//  decode and the SDRAM command engine.
//  Stretches the Z80 cycle via cpu_wait_n and back-pressures the downloader via dl_wait.
// PARAMETERS
//  ADDR_W       25   byte address width into SDRAM
//  RFSH_PERIOD  160  clk cycles between refresh requests (about 7.5 us at 21.48 MHz)
//  RFSH_URGENT  2    pending-refresh count at which refresh overrides CPU priority
// PORTS
//  clk          in   1       system clock (single clock domain)
//  reset_n      in   1       synchronous, active-low reset
//  cpu_req      in   1       level: slot selected & rd_n low & mreq_n low
//  cpu_addr     in   ADDR_W  mapped cartridge byte address, stable while cpu_req
//  cpu_dout     out  8       read data to CPU mux
//  cpu_wait_n   out  1       active-low Z80 wait
//  dl_wr        in   1       1-clk download write strobe (ioctl_wr & ioctl_isROM)
//  dl_addr      in   ADDR_W  download byte address
//  dl_data      in   8       download byte
//  dl_wait      out  1       buffer full; downloader must hold off
//  dl_overrun   out  1       sticky: dl_wr arrived while the buffer was full
//  mem_req      out  1       request to SDRAM engine, held until mem_ack
//  mem_rfsh     out  1       request is a refresh (mem_we/addr don't-care)
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  request address, held with mem_req
//  mem_din      out  8       write data
//  mem_dout     in   8       read data, valid in the mem_ack cycle
//  mem_ack      in   1       1-clk completion pulse
// BEHAVIOUR
//  Reset values: mem_req=0, mem_rfsh=0, mem_we=0, cpu_dout=8'hFF, dl_wait=0, dl_overrun=0.
//    Reset also clears the refresh counter, the pending count and the download buffer.
//  Reset mid-transaction: drop mem_req immediately; discard any late mem_ack.
//  FSM states: IDLE, CPU, RFSH, DL. In each non-IDLE state mem_req/mem_* are stable until mem_ack.
//    On mem_ack, return to IDLE and deassert mem_req in the same clock.
//  Arbitration in IDLE (one grant per clock), highest priority first:
//    1. RFSH if rfsh_pend >= RFSH_URGENT
//    2. CPU if a CPU request is pending
//    3. RFSH if rfsh_pend > 0
//    4. DL if the download buffer is full
//  Refresh counter:
//    - Counts 0..RFSH_PERIOD-1; at wrap, rfsh_pend increments (2-bit, saturates at 3).
//    - Grant of RFSH decrements rfsh_pend; a wrap in the same cycle nets to zero change.
//  CPU handshake:
//    - A new request is the rising edge of cpu_req. Latch cpu_addr; set cpu_pend.
//    - On its mem_ack: cpu_dout <= mem_dout; cpu_valid <= 1.
//    - cpu_valid and cpu_pend clear when cpu_req falls.
//    - cpu_wait_n = ~(cpu_req & ~cpu_valid), combinational. Low from the first cpu_req cycle;
//      high in the cycle after ack.
//    - cpu_req falling before ack (reset/abort): the access completes, data is discarded,
//      cpu_valid stays 0.
//  Download buffer (one entry):
//    - dl_wr when empty: latch addr/data; dl_wait <= 1.
//    - DL ack: empty the buffer; dl_wait <= 0 next clock.
//    - dl_wr when full: ignored; dl_overrun <= 1 (cleared only by reset).
//    - dl_wr in the same cycle as the DL ack: accepted (buffer refills; dl_wait stays 1).
//  Worst-case CPU latency: one in-flight op + one urgent refresh + its own access.
// CONFIGURATION
//  CART_RDCACHE_EN defined:
//    - Single-entry read cache {tag=cpu_addr, data, valid}.
//    - CPU request hitting a valid tag: cpu_dout loaded and cpu_valid set next clock; no mem_req.
//    - Miss: normal path; the cache fills on mem_ack.
//    - A DL write to the cached address invalidates the entry. Reset invalidates the entry.
//  Undefined: every CPU read goes to SDRAM; no cache storage is synthesised.
// STRUCTURE
//  Shared package msx_mem_pkg:
//    - enum arb_state_t {IDLE,CPU,RFSH,DL}
//    - localparams for default RFSH_PERIOD and CART_ADDR_W
//  Sub-module arb_rfsh_timer: counter, pend increment/decrement, urgent flag.
// TESTING
//  1. CPU read 0x004000; engine acks 3 clks later with 8'hA5 -> cpu_wait_n low 4 clks, cpu_dout=8'hA5, exactly one mem_req.
//  2. Idle for 3*RFSH_PERIOD clks -> three mem_rfsh grants; rfsh_pend returns to 0; no CPU/DL grants.
//  3. rfsh_pend=2 while CPU and DL are both pending -> grant order RFSH, CPU, RFSH, DL.
//  4. dl_wr 0x000000/8'h11, then dl_wr 0x000001/8'h22 while full -> second byte dropped; dl_overrun=1; only 8'h11 written.
//  5. reset_n low mid-CPU access with ack arriving after reset -> all outputs at reset values; late ack ignored.
//  6. CART_RDCACHE_EN: two reads of 0x008000 -> second has no mem_req, wait 1 clk; DL write to 0x008000 -> third read misses.

Source files
------------

// File: rtl/msx_mem_pkg.sv
// Shared cartridge-memory types: arbiter state encoding and default sizing.
package msx_mem_pkg;

    localparam int unsigned CART_ADDR_W     = 25;
    localparam int unsigned RFSH_PERIOD_DEF = 160;
    localparam int unsigned RFSH_URGENT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        RFSH = 2'd2,
        DL   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Request/acknowledge bus between the cartridge arbiter and the SDRAM command engine.
interface cart_mem_arbiter_if
    import msx_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = CART_ADDR_W
);
    logic              mem_req;
    logic              mem_rfsh;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    modport master (
        output mem_req, mem_rfsh, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_req, mem_rfsh, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/arb_rfsh_timer.sv
// Auto-refresh interval counter with a saturating 2-bit pending-refresh count.
module arb_rfsh_timer
    import msx_mem_pkg::*;
#(
    parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int unsigned RFSH_URGENT = RFSH_URGENT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic grant_i,
    output logic pend_c,
    output logic urgent_c
);
    localparam int unsigned CNT_W = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic             wrap_c;

    // Next interval count and pending count; a wrap coinciding with a grant cancels out.
    always_comb begin
        wrap_c = (cnt_q == CNT_W'(RFSH_PERIOD - 1));
        cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
        pend_d = pend_q;
        if (wrap_c && !grant_i && (pend_q != 2'd3)) begin
            pend_d = pend_q + 2'd1;
        end else if (!wrap_c && grant_i && (pend_q != 2'd0)) begin
            pend_d = pend_q - 2'd1;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            pend_q <= 2'd0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_c   = (pend_q != 2'd0);
    assign urgent_c = (32'(pend_q) >= RFSH_URGENT);

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge SDRAM port between Z80 slot reads, ROM-download writes and refresh.
// Optional single-entry read cache is built when CART_RDCACHE_EN is defined.
module cart_mem_arbiter
    import msx_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = CART_ADDR_W,
    parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int unsigned RFSH_URGENT = RFSH_URGENT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic [7:0]         cpu_dout,
    output logic               cpu_wait_n,
    input  logic               dl_wr,
    input  logic [ADDR_W-1:0]  dl_addr,
    input  logic [7:0]         dl_data,
    output logic               dl_wait,
    output logic               dl_overrun,
    cart_mem_arbiter_if.master mem
);
    arb_state_t        state_q, state_d;
    logic              cpu_req_q, cpu_pend_q, cpu_pend_d, cpu_valid_q, cpu_valid_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic              dl_full_q, dl_full_d, dl_overrun_q, dl_overrun_d;
    logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
    logic [7:0]        dl_data_q, dl_data_d;
    logic              mem_req_q, mem_req_d, mem_rfsh_q, mem_rfsh_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              cpu_rise_c, cpu_want_c, cache_hit_c, grant_rfsh_c, grant_cpu_c;
    logic              ack_c, cpu_ack_c, dl_ack_c, rfsh_pend_c, rfsh_urgent_c;
    logic [7:0]        cache_rd_c;
`ifdef CART_RDCACHE_EN
    logic [ADDR_W-1:0] cache_tag_q, cache_tag_d;
    logic [7:0]        cache_data_q, cache_data_d;
    logic              cache_valid_q, cache_valid_d;
`endif

    arb_rfsh_timer #(
        .RFSH_PERIOD (RFSH_PERIOD),
        .RFSH_URGENT (RFSH_URGENT)
    ) u_rfsh_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .grant_i  (grant_rfsh_c),
        .pend_c   (rfsh_pend_c),
        .urgent_c (rfsh_urgent_c)
    );

    // Arbitration, transaction tracking, CPU/download handshakes and read cache next-state.
    always_comb begin
        state_d      = state_q;
        cpu_pend_d   = cpu_pend_q;
        cpu_valid_d  = cpu_valid_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_dout_d   = cpu_dout_q;
        dl_full_d    = dl_full_q;
        dl_overrun_d = dl_overrun_q;
        dl_addr_d    = dl_addr_q;
        dl_data_d    = dl_data_q;
        mem_req_d    = mem_req_q;
        mem_rfsh_d   = mem_rfsh_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        grant_rfsh_c = 1'b0;
        grant_cpu_c  = 1'b0;
`ifdef CART_RDCACHE_EN
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        cache_valid_d = cache_valid_q;
        cache_hit_c   = cache_valid_q && (cache_tag_q == cpu_addr);
        cache_rd_c    = cache_data_q;
`else
        cache_hit_c   = 1'b0;
        cache_rd_c    = 8'hFF;
`endif

        // Acks only count while an op is in flight; stray acks in IDLE are dropped.
        cpu_rise_c = cpu_req && !cpu_req_q;
        cpu_want_c = cpu_pend_q || (cpu_rise_c && !cache_hit_c);
        ack_c      = mem.mem_ack && (state_q != IDLE);
        cpu_ack_c  = ack_c && (state_q == CPU);
        dl_ack_c   = ack_c && (state_q == DL);

        unique case (state_q)
            IDLE: begin
                if (rfsh_urgent_c) begin
                    grant_rfsh_c = 1'b1;
                end else if (cpu_want_c) begin
                    grant_cpu_c = 1'b1;
                end else if (rfsh_pend_c) begin
                    grant_rfsh_c = 1'b1;
                end else if (dl_full_q) begin
                    state_d    = DL;
                    mem_req_d  = 1'b1;
                    mem_rfsh_d = 1'b0;
                    mem_we_d   = 1'b1;
                    mem_addr_d = dl_addr_q;
                    mem_din_d  = dl_data_q;
                end
                if (grant_rfsh_c) begin
                    state_d    = RFSH;
                    mem_req_d  = 1'b1;
                    mem_rfsh_d = 1'b1;
                    mem_we_d   = 1'b0;
                end
                if (grant_cpu_c) begin
                    state_d    = CPU;
                    mem_req_d  = 1'b1;
                    mem_rfsh_d = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_rise_c ? cpu_addr : cpu_addr_q;
                end
            end
            default: begin
                if (mem.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_rfsh_d = 1'b0;
                    mem_we_d   = 1'b0;
                end
            end
        endcase

        // CPU side: a read is only delivered to the request that launched it.
        if (cpu_rise_c) begin
            cpu_addr_d = cpu_addr;
        end
        if (!cpu_req) begin
            cpu_pend_d  = 1'b0;
            cpu_valid_d = 1'b0;
        end else begin
            if (grant_cpu_c) begin
                cpu_pend_d = 1'b0;
            end else if (cpu_rise_c && !cache_hit_c) begin
                cpu_pend_d = 1'b1;
            end
            if (cpu_ack_c && cpu_req_q && !cpu_pend_q) begin
                cpu_dout_d  = mem.mem_dout;
                cpu_valid_d = 1'b1;
            end else if (cpu_rise_c && cache_hit_c) begin
                cpu_dout_d  = cache_rd_c;
                cpu_valid_d = 1'b1;
            end
        end

        // Download buffer: a write landing with the DL ack refills the slot.
        if (dl_ack_c) begin
            dl_full_d = 1'b0;
        end
        if (dl_wr) begin
            if (!dl_full_q || dl_ack_c) begin
                dl_full_d = 1'b1;
                dl_addr_d = dl_addr;
                dl_data_d = dl_data;
            end else begin
                dl_overrun_d = 1'b1;
            end
        end

`ifdef CART_RDCACHE_EN
        // Fill on every completed CPU read; a landed download write to the tag invalidates.
        if (cpu_ack_c) begin
            cache_tag_d   = mem_addr_q;
            cache_data_d  = mem.mem_dout;
            cache_valid_d = 1'b1;
        end else if (dl_ack_c && (mem_addr_q == cache_tag_q)) begin
            cache_valid_d = 1'b0;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cpu_req_q    <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_valid_q  <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_dout_q   <= 8'hFF;
            dl_full_q    <= 1'b0;
            dl_overrun_q <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= 8'h00;
            mem_req_q    <= 1'b0;
            mem_rfsh_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cpu_req_q    <= cpu_req;
            cpu_pend_q   <= cpu_pend_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_dout_q   <= cpu_dout_d;
            dl_full_q    <= dl_full_d;
            dl_overrun_q <= dl_overrun_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            mem_req_q    <= mem_req_d;
            mem_rfsh_q   <= mem_rfsh_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

`ifdef CART_RDCACHE_EN
    // Read-cache entry registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cache_tag_q   <= '0;
            cache_data_q  <= 8'h00;
            cache_valid_q <= 1'b0;
        end else begin
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            cache_valid_q <= cache_valid_d;
        end
    end
`endif

    assign cpu_dout     = cpu_dout_q;
    assign cpu_wait_n   = ~(cpu_req & ~cpu_valid_q);
    assign dl_wait      = dl_full_q;
    assign dl_overrun   = dl_overrun_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_rfsh = mem_rfsh_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus randomized reads/downloads against
// a byte-memory reference model; define CART_RDCACHE_EN to also exercise the read cache.
module tb_cart_mem_arbiter;
    import msx_mem_pkg::*;

    localparam int unsigned ADDR_W = CART_ADDR_W;
    localparam int unsigned P      = RFSH_PERIOD_DEF;
    localparam int K_RFSH = 0;
    localparam int K_CPU  = 1;
    localparam int K_DLW  = 2;

    typedef struct {
        logic              rfsh;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } op_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic              cpu_wait_n;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic              dl_overrun;

    int n_total = 0;
    int n_bad   = 0;

    op_t        op_log[$];
    logic [7:0] sdram[logic [ADDR_W-1:0]];
    logic [7:0] preset[logic [ADDR_W-1:0]];
    logic [7:0] model_mem[logic [ADDR_W-1:0]];
    int         op_lat    = 2;
    bit         rand_lat  = 1'b0;
    int         stray_req = 0;

    always #5 clk = ~clk;

    cart_mem_arbiter_if #(.ADDR_W(ADDR_W)) mem_if ();

    cart_mem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .dl_overrun (dl_overrun),
        .mem        (mem_if.master)
    );

    function automatic logic [7:0] def_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Content SDRAM must hold: what the bench downloaded, else preloaded, else background.
    function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        if (preset.exists(a))    return preset[a];
        return def_byte(a);
    endfunction

    function automatic int kind_of(input op_t o);
        return o.rfsh ? K_RFSH : (o.we ? K_DLW : K_CPU);
    endfunction

    function automatic int count_kind(input int from, input int k);
        int n = 0;
        for (int i = from; i < op_log.size(); i++) if (kind_of(op_log[i]) == k) n++;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM engine: acks in the Nth cycle of a request, logs every new request.
    initial begin
        int cnt = 0;
        int lat = 1;
        int stray_seen = 0;
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_if.mem_ack = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen      = stray_req;
                mem_if.mem_ack  = 1'b1;
                mem_if.mem_dout = 8'h3C;
            end else if (mem_if.mem_req) begin
                if (cnt == 0) begin
                    op_log.push_back('{mem_if.mem_rfsh, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_din});
                    lat = mem_if.mem_rfsh ? 1 : (rand_lat ? int'($urandom_range(1, 4)) : op_lat);
                end
                cnt++;
                if (cnt >= lat) begin
                    cnt            = 0;
                    mem_if.mem_ack = 1'b1;
                    if (!mem_if.mem_rfsh) begin
                        if (mem_if.mem_we) sdram[mem_if.mem_addr] = mem_if.mem_din;
                        else mem_if.mem_dout = sdram.exists(mem_if.mem_addr) ? sdram[mem_if.mem_addr]
                            : (preset.exists(mem_if.mem_addr) ? preset[mem_if.mem_addr] : def_byte(mem_if.mem_addr));
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_req = 1'b0;
        dl_wr   = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic dl_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit keep);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick(1);
        dl_wr = 1'b0;
        if (keep) model_mem[a] = d;
    endtask

    task automatic wait_dl_idle(input string tag);
        int n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (!dl_wait) break;
            n++;
        end
        if (n >= 500) check_val({tag, "_dl_timeout"}, 32'(dl_wait), 32'd0);
        tick(1);
    endtask

    // Full Z80 read: counts wait cycles and checks the delivered byte.
    task automatic cpu_read(input logic [ADDR_W-1:0] a, input string tag, output int low);
        low      = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        while (low < 1000) begin
            @(negedge clk);
            if (cpu_wait_n) break;
            low++;
        end
        if (low >= 1000) check_val({tag, "_timeout"}, 32'(cpu_wait_n), 32'd1);
        else check_val({tag, "_dout"}, 32'(cpu_dout), 32'(exp_byte(a)));
        tick(1);
        cpu_req = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int low;
        int base;
        int n;
        int exp_k[6];
        logic [ADDR_W-1:0] a;

        cpu_addr = '0;
        dl_addr  = '0;
        dl_data  = 8'h00;
        do_reset();

        // Reset state
        @(negedge clk);
        check_val("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        check_val("rst_mem_rfsh", 32'(mem_if.mem_rfsh), 32'd0);
        check_val("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
        check_val("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
        check_val("rst_dl_wait", 32'(dl_wait), 32'd0);
        check_val("rst_overrun", 32'(dl_overrun), 32'd0);
        check_val("rst_wait_n", 32'(cpu_wait_n), 32'd1);

        // 1: single CPU read, engine acks in the 3rd request cycle
        do_reset();
        preset[25'h004000] = 8'hA5;
        op_lat = 3;
        base = op_log.size();
        cpu_read(25'h004000, "t1", low);
        check_val("t1_wait_cycles", 32'(low), 32'd4);
        check_val("t1_nreq", 32'(op_log.size() - base), 32'd1);
        if (op_log.size() > base) begin
            check_val("t1_kind", 32'(kind_of(op_log[base])), 32'(K_CPU));
            check_val("t1_addr", 32'(op_log[base].addr), 32'h004000);
        end
        @(negedge clk);
        check_val("t1_wait_n_released", 32'(cpu_wait_n), 32'd1);

        // 2: idle for three refresh periods
        do_reset();
        base = op_log.size();
        tick(3 * P + P / 2);
        check_val("t2_rfsh_grants", 32'(count_kind(base, K_RFSH)), 32'd3);
        check_val("t2_other_grants", 32'(count_kind(base, K_CPU) + count_kind(base, K_DLW)), 32'd0);

        // 3: two refreshes pile up behind a long DL op while CPU and DL wait
        do_reset();
        op_lat = 2;
        base = op_log.size();
        n = 0;
        while (op_log.size() == base && n < 2 * P) begin
            tick(1);
            n++;
        end
        check_val("t3_first_rfsh_seen", 32'(op_log.size() > base), 32'd1);
        op_lat = 2 * P + P / 2;
        dl_write(25'h000010, 8'h33, 1'b1);
        tick(20);
        cpu_req  = 1'b1;
        cpu_addr = 25'h004001;
        n = 0;
        while (!mem_if.mem_ack && n < 3 * P) begin
            tick(1);
            n++;
        end
        op_lat = 2;
        dl_write(25'h000011, 8'h44, 1'b1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (cpu_wait_n) break;
            n++;
        end
        check_val("t3_cpu_dout", 32'(cpu_dout), 32'(exp_byte(25'h004001)));
        tick(1);
        cpu_req = 1'b0;
        wait_dl_idle("t3");
        exp_k = '{K_RFSH, K_DLW, K_RFSH, K_CPU, K_RFSH, K_DLW};
        check_val("t3_nops", 32'(op_log.size() - base >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (base + i < op_log.size())
                check_val($sformatf("t3_op%0d", i), 32'(kind_of(op_log[base + i])), 32'(exp_k[i]));
        end
        if (base + 5 < op_log.size()) check_val("t3_refill_data", 32'(op_log[base + 5].din), 32'h44);
        check_val("t3_sdram_10", 32'(sdram[25'h000010]), 32'h33);

        // 4: second download byte while the buffer is full is dropped
        op_lat = 3;
        base = op_log.size();
        dl_write(25'h000000, 8'h11, 1'b1);
        dl_write(25'h000001, 8'h22, 1'b0);
        wait_dl_idle("t4");
        tick(3);
        @(negedge clk);
        check_val("t4_overrun", 32'(dl_overrun), 32'd1);
        check_val("t4_dl_writes", 32'(count_kind(base, K_DLW)), 32'd1);
        check_val("t4_sdram_0", 32'(sdram.exists(25'h000000) ? sdram[25'h000000] : 8'h00), 32'h11);
        check_val("t4_addr1_untouched", 32'(sdram.exists(25'h000001)), 32'd0);

        // 5: reset in the middle of a CPU access, then a late ack
        tick(1);
        op_lat   = 10;
        cpu_req  = 1'b1;
        cpu_addr = 25'h004002;
        tick(4);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        tick(1);
        reset_n = 1'b1;
        stray_req++;
        base = op_log.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("t5_mem_req_%0d", i), 32'(mem_if.mem_req), 32'd0);
            check_val($sformatf("t5_cpu_dout_%0d", i), 32'(cpu_dout), 32'hFF);
        end
        check_val("t5_mem_rfsh", 32'(mem_if.mem_rfsh), 32'd0);
        check_val("t5_mem_we", 32'(mem_if.mem_we), 32'd0);
        check_val("t5_dl_wait", 32'(dl_wait), 32'd0);
        check_val("t5_overrun", 32'(dl_overrun), 32'd0);
        check_val("t5_wait_n", 32'(cpu_wait_n), 32'd1);
        check_val("t5_no_ops", 32'(op_log.size() - base), 32'd0);
        tick(1);
        op_lat = 2;
        cpu_read(25'h004003, "t5_after", low);

`ifdef CART_RDCACHE_EN
        // 6: read cache hit, then invalidation by a download write
        do_reset();
        base = op_log.size();
        cpu_read(25'h008000, "t6_r1", low);
        check_val("t6_r1_cpu_ops", 32'(count_kind(base, K_CPU)), 32'd1);
        cpu_read(25'h008000, "t6_r2", low);
        check_val("t6_r2_wait", 32'(low), 32'd1);
        check_val("t6_r2_cpu_ops", 32'(count_kind(base, K_CPU)), 32'd1);
        dl_write(25'h008000, 8'h99, 1'b1);
        wait_dl_idle("t6");
        cpu_read(25'h008000, "t6_r3", low);
        check_val("t6_r3_cpu_ops", 32'(count_kind(base, K_CPU)), 32'd2);
`endif

        // Randomized reads and downloads with random engine latency
        do_reset();
        rand_lat = 1'b1;
        for (int it = 0; it < 60; it++) begin
            a = ($urandom_range(0, 4) == 0) ? 25'h008000 : 25'(32'h4000 + $urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                wait_dl_idle("rnd");
                cpu_read(a, $sformatf("rnd%0d", it), low);
                check_val($sformatf("rnd%0d_waited", it), 32'(low > 0), 32'd1);
            end else begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) begin
                    wait_dl_idle("rnd");
                    dl_write(a, 8'($urandom), 1'b1);
                    a = 25'(32'h4000 + $urandom_range(0, 7));
                end
            end
            tick($urandom_range(0, 3));
        end
        wait_dl_idle("rnd_end");
        check_val("rnd_overrun", 32'(dl_overrun), 32'd0);
        foreach (model_mem[k]) begin
            check_val($sformatf("rnd_sdram_%0h", k), 32'(sdram.exists(k) ? sdram[k] : 8'h00), 32'(model_mem[k]));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
